// File: rtl/gather_wb_if.sv
// Write-side bus bundle of gather_wb: burst command, write data and write response.
interface gather_wb_if #(
    parameter int unsigned AXI_DW = 512,
    parameter int unsigned AXI_AW = 64
);
    logic [AXI_AW-1:0]   wr_addr;
    logic [7:0]          wr_len;
    logic                wr_valid;
    logic                wr_ready;
    logic [AXI_DW-1:0]   wr_data;
    logic [AXI_DW/8-1:0] wr_strb;
    logic                wr_dvalid;
    logic                wr_dlast;
    logic                wr_dready;
    logic                wr_bvalid;
    logic [1:0]          wr_bresp;

    modport master (
        output wr_addr, wr_len, wr_valid, wr_data, wr_strb, wr_dvalid, wr_dlast,
        input  wr_ready, wr_dready, wr_bvalid, wr_bresp
    );

    modport slave (
        input  wr_addr, wr_len, wr_valid, wr_data, wr_strb, wr_dvalid, wr_dlast,
        output wr_ready, wr_dready, wr_bvalid, wr_bresp
    );
endinterface

// File: rtl/gather_wb.sv
// Write-back stage: buffers non-stallable read beats in a FWFT FIFO and drains them as 4 KB-bounded bursts.
// Optional GATHER_WB_SWAP64_EN reverses the 64-bit lane order of every written beat.
module gather_wb #(
    parameter int unsigned AXI_DW  = 512,
    parameter int unsigned AXI_AW  = 64,
    parameter int unsigned FIFO_AW = 7
) (
    input  logic              axi_clk,
    input  logic              axi_rst,
    input  logic              cfg_start,
    input  logic [AXI_AW-1:0] cfg_wb_addr,
    input  logic [31:0]       cfg_total_beats,
    input  logic              rd_valid,
    input  logic [AXI_DW-1:0] rd_data,
    input  logic [2:0]        rd_resp,
    gather_wb_if.master       wb,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam int unsigned LANES = AXI_DW / 64;

    typedef enum logic [2:0] {IDLE, CMD, DATA, WAIT_RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic [AXI_AW-1:0]   cur_addr_q, cur_addr_d;
    logic [31:0]         remaining_q, remaining_d;
    logic [7:0]          outstanding_q, outstanding_d;
    logic [6:0]          blen_q, blen_d;
    logic [6:0]          beat_q, beat_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [FIFO_AW-1:0]  wptr_q, wptr_d;
    logic [FIFO_AW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [AXI_DW-1:0]   mem [DEPTH];

    logic [6:0]          room;
    logic [6:0]          burst_len;
    logic                fifo_full;
    logic                capture;
    logic                push;
    logic                pop;
    logic                cmd_ok;
    logic                cmd_fire;
    logic                resp_dec;
    logic                last_beat;
    logic [AXI_DW-1:0]   head;

    // Bursts stop at the next 4 KB boundary (64 beats of 64 B per 4 KB page).
    assign room      = 7'd64 - {1'b0, cur_addr_q[11:6]};
    assign burst_len = (remaining_q < 32'(room)) ? remaining_q[6:0] : room;

    assign busy      = (state_q == CMD) || (state_q == DATA) || (state_q == WAIT_RESP);
    assign fifo_full = (cnt_q == CW'(DEPTH));
    assign capture   = busy && rd_valid;
    assign push      = capture && !fifo_full;
    assign pop       = (state_q == DATA) && wb.wr_dready;
    assign cmd_ok    = (cnt_q >= CW'(burst_len));
    assign cmd_fire  = (state_q == CMD) && cmd_ok && wb.wr_ready;
    assign resp_dec  = wb.wr_bvalid && (outstanding_q != '0);
    assign last_beat = (beat_q == blen_q - 7'd1);
    assign head      = mem[rptr_q];

    always_ff @(posedge axi_clk) begin
        if (push) begin
            mem[wptr_q] <= rd_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_addr_d    = cur_addr_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        blen_d        = blen_q;
        beat_d        = beat_q;
        done_d        = done_q;
        err_d         = err_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        cnt_d         = cnt_q;

        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;

        if (cmd_fire && !resp_dec)      outstanding_d = outstanding_q + 8'd1;
        else if (!cmd_fire && resp_dec) outstanding_d = outstanding_q - 8'd1;

        if (capture && (fifo_full || (rd_resp != '0))) err_d = 1'b1;
        if (wb.wr_bvalid && (wb.wr_bresp != '0))       err_d = 1'b1;

        if (state_q == DONE) done_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    cur_addr_d    = cfg_wb_addr;
                    remaining_d   = cfg_total_beats;
                    outstanding_d = '0;
                    blen_d        = '0;
                    beat_d        = '0;
                    done_d        = 1'b0;
                    err_d         = 1'b0;
                    wptr_d        = '0;
                    rptr_d        = '0;
                    cnt_d         = '0;
                    state_d       = (cfg_total_beats == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                if (cmd_fire) begin
                    cur_addr_d  = cur_addr_q + (AXI_AW'(burst_len) << 6);
                    remaining_d = remaining_q - 32'(burst_len);
                    blen_d      = burst_len;
                    beat_d      = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (pop) begin
                    beat_d = beat_q + 7'd1;
                    if (last_beat) state_d = (remaining_q != '0) ? CMD : WAIT_RESP;
                end
            end
            // Looks at the post-response count so the final response leaves here in the same cycle.
            WAIT_RESP: begin
                if (outstanding_d == '0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            blen_q        <= '0;
            beat_q        <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            blen_q        <= blen_d;
            beat_q        <= beat_d;
            done_q        <= done_d;
            err_q         <= err_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            cnt_q         <= cnt_d;
        end
    end

`ifdef GATHER_WB_SWAP64_EN
    function automatic logic [AXI_DW-1:0] lane_swap(input logic [AXI_DW-1:0] d);
        logic [AXI_DW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            r[i*64 +: 64] = d[(LANES-1-i)*64 +: 64];
        end
        return r;
    endfunction

    assign wb.wr_data = (state_q == DATA) ? lane_swap(head) : '0;
`else
    assign wb.wr_data = (state_q == DATA) ? head : '0;
`endif

    assign wb.wr_addr   = (state_q == CMD) ? cur_addr_q : '0;
    assign wb.wr_len    = (state_q == CMD) ? 8'(burst_len - 7'd1) : '0;
    assign wb.wr_valid  = (state_q == CMD) && cmd_ok;
    assign wb.wr_dvalid = (state_q == DATA);
    assign wb.wr_dlast  = (state_q == DATA) && last_beat;
    assign wb.wr_strb   = '1;
    assign done         = done_q;
    assign err          = err_q;
endmodule
